cfg_write_arbiter: RTL and testbench

CFG_WRITE_ARBITER -- requirements
Module: cfg_write_arbiter

---
 rtl/cfg_write_arbiter.sv | 128 ++++++++++++
 tb/tb_cfg_write_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cfg_write_arbiter.sv
// Round-robin arbiter merging host and supervisor writes onto one configuration write port.
// A legal write to SERVICE (addr 2) blocks further grants for a 3-cycle hold-off.
module cfg_write_arbiter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        H_VALID,
   input  logic [2:0]  H_ABUS,
   input  logic [15:0] H_DBUS,
   output logic        H_READY,
   output logic        H_ERR,
   input  logic        S_VALID,
   input  logic [2:0]  S_ABUS,
   input  logic [15:0] S_DBUS,
   output logic        S_READY,
   output logic        S_ERR,
   input  logic        LOCK,
   output logic        WREN,
   output logic [2:0]  ABUS,
   output logic [15:0] DBUS,
   output logic        BUSY
);

   typedef enum logic {IDLE, HOLDOFF} state_t;

   localparam logic LAST_HOST = 1'b0;
   localparam logic LAST_SUP  = 1'b1;
   localparam logic [2:0] ADDR_SERVICE = 3'd2;
   localparam logic [2:0] ADDR_RST_LMT = 3'd3;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        wren_q, wren_d;
   logic [2:0]  abus_q, abus_d;
   logic [15:0] dbus_q, dbus_d;
   logic        herr_q, herr_d;
   logic        serr_q, serr_d;
   logic        gnt_h, gnt_s;
   logic        h_legal, s_legal;
   logic        sel_legal;
   logic [2:0]  sel_abus;
   logic [15:0] sel_dbus;

   assign h_legal = !(LOCK && H_ABUS[2]);
   assign s_legal = (S_ABUS == ADDR_SERVICE) || (S_ABUS == ADDR_RST_LMT);

   always_comb begin
      gnt_h     = 1'b0;
      gnt_s     = 1'b0;
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      wren_d    = 1'b0;
      abus_d    = abus_q;
      dbus_d    = dbus_q;
      herr_d    = 1'b0;
      serr_d    = 1'b0;
      sel_legal = 1'b0;
      sel_abus  = H_ABUS;
      sel_dbus  = H_DBUS;
      case (state_q)
         IDLE: begin
            // On a tie the requester not granted last wins; a lone requester always wins.
            if (!RST) begin
               if (H_VALID && (!S_VALID || last_q == LAST_SUP)) gnt_h = 1'b1;
               else if (S_VALID)                              gnt_s = 1'b1;
            end
            if (gnt_h) begin
               last_d    = LAST_HOST;
               sel_legal = h_legal;
               herr_d    = !h_legal;
            end else if (gnt_s) begin
               last_d    = LAST_SUP;
               sel_legal = s_legal;
               sel_abus  = S_ABUS;
               sel_dbus  = S_DBUS;
               serr_d    = !s_legal;
            end
            if (sel_legal) begin
               wren_d = 1'b1;
               abus_d = sel_abus;
               dbus_d = sel_dbus;
               if (sel_abus == ADDR_SERVICE) begin
                  state_d = HOLDOFF;
                  cnt_d   = 2'd2;
               end
            end
         end
         HOLDOFF: begin
            if (cnt_q == 2'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         last_q  <= LAST_SUP;
         wren_q  <= 1'b0;
         abus_q  <= 3'd0;
         dbus_q  <= 16'd0;
         herr_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         wren_q  <= wren_d;
         abus_q  <= abus_d;
         dbus_q  <= dbus_d;
         herr_q  <= herr_d;
         serr_q  <= serr_d;
      end
   end

   assign H_READY = gnt_h;
   assign S_READY = gnt_s;
   assign H_ERR   = herr_q;
   assign S_ERR   = serr_q;
   assign WREN    = wren_q;
   assign ABUS    = abus_q;
   assign DBUS    = dbus_q;
   assign BUSY    = (state_q == HOLDOFF);

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter; expected writes are queued at acceptance and popped on WREN.
module tb_cfg_write_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        H_VALID = 1'b0, S_VALID = 1'b0, LOCK = 1'b0;
   logic [2:0]  H_ABUS = 3'd0, S_ABUS = 3'd0;
   logic [15:0] H_DBUS = 16'd0, S_DBUS = 16'd0;
   logic        H_READY, H_ERR, S_READY, S_ERR, WREN, BUSY;
   logic [2:0]  ABUS;
   logic [15:0] DBUS;

   int checks = 0;
   int errors = 0;
   logic [18:0] exp_q[$];

   always #5 CLK = ~CLK;

   cfg_write_arbiter dut (
      .CLK(CLK), .RST(RST),
      .H_VALID(H_VALID), .H_ABUS(H_ABUS), .H_DBUS(H_DBUS), .H_READY(H_READY), .H_ERR(H_ERR),
      .S_VALID(S_VALID), .S_ABUS(S_ABUS), .S_DBUS(S_DBUS), .S_READY(S_READY), .S_ERR(S_ERR),
      .LOCK(LOCK), .WREN(WREN), .ABUS(ABUS), .DBUS(DBUS), .BUSY(BUSY)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then settle; any WREN must match the oldest queued write.
   task automatic tick();
      logic [18:0] e;
      @(posedge CLK);
      #1;
      if (WREN === 1'b1) begin
         chk("wren_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr_data", {13'd0, ABUS, DBUS}, {13'd0, e});
         end
      end
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // Reset with a host request presented: must not be accepted.
      H_VALID = 1'b1; H_ABUS = 3'd1; H_DBUS = 16'h1234;
      settle();
      chk("rst_h_ready", 32'(H_READY), 0);
      chk("rst_s_ready", 32'(S_READY), 0);
      tick(); tick();
      chk("rst_outs", {24'd0, WREN, BUSY, H_ERR, S_ERR, 1'b0, ABUS}, 0);
      chk("rst_dbus", 32'(DBUS), 0);
      H_VALID = 1'b0;

      // Single host write straight after reset.
      RST = 1'b0;
      H_VALID = 1'b1; H_ABUS = 3'd0; H_DBUS = 16'h00FF;
      settle();
      chk("h_ready_first", 32'(H_READY), 1);
      chk("s_ready_first", 32'(S_READY), 0);
      exp_q.push_back({3'd0, 16'h00FF});
      tick();
      chk("wren_first", 32'(WREN), 1);
      H_VALID = 1'b0;
      tick();
      chk("wren_drop", 32'(WREN), 0);
      chk("hold_abus_dbus", {13'd0, ABUS, DBUS}, {13'd0, 3'd0, 16'h00FF});

      // Re-reset so LAST returns to supervisor, then a tie: host first, supervisor next.
      RST = 1'b1; tick(); RST = 1'b0;
      H_VALID = 1'b1; H_ABUS = 3'd1; H_DBUS = 16'h000A;
      S_VALID = 1'b1; S_ABUS = 3'd3; S_DBUS = 16'h0005;
      settle();
      chk("tie_h_ready", {30'd0, H_READY, S_READY}, 32'b10);
      exp_q.push_back({3'd1, 16'h000A});
      tick();
      chk("tie_wren1", 32'(WREN), 1);
      H_VALID = 1'b0;
      settle();
      chk("tie_s_ready", {30'd0, H_READY, S_READY}, 32'b01);
      exp_q.push_back({3'd3, 16'h0005});
      tick();
      chk("tie_wren2", 32'(WREN), 1);
      S_VALID = 1'b0;
      tick();
      chk("tie_idle", 32'(WREN), 0);

      // Locked host write to addr 5 errors; LOCK drops right after acceptance.
      LOCK = 1'b1; H_VALID = 1'b1; H_ABUS = 3'd5; H_DBUS = 16'h0055;
      settle();
      chk("lock_h_ready", 32'(H_READY), 1);
      tick();
      H_VALID = 1'b0; LOCK = 1'b0;
      chk("lock_err", {29'd0, H_ERR, S_ERR, WREN}, 32'b100);
      tick();
      chk("lock_err_pulse", 32'(H_ERR), 0);
      // Addr 3 is below the protected range even when locked.
      LOCK = 1'b1; H_VALID = 1'b1; H_ABUS = 3'd3; H_DBUS = 16'h0033;
      settle();
      exp_q.push_back({3'd3, 16'h0033});
      tick();
      H_VALID = 1'b0; LOCK = 1'b0;
      chk("lock_addr3_wr", {30'd0, WREN, H_ERR}, 32'b10);
      // Unlocked, addr 5 writes.
      H_VALID = 1'b1; H_ABUS = 3'd5; H_DBUS = 16'h0066;
      settle();
      exp_q.push_back({3'd5, 16'h0066});
      tick();
      H_VALID = 1'b0;
      chk("unlock_abus", {29'd0, WREN, H_ERR, 1'b0} | 32'(ABUS) << 4, {29'd0, 3'b100} | 32'd5 << 4);

      // Supervisor to an illegal address.
      S_VALID = 1'b1; S_ABUS = 3'd0; S_DBUS = 16'h0BAD;
      settle();
      chk("s_ill_ready", 32'(S_READY), 1);
      tick();
      S_VALID = 1'b0;
      chk("s_ill_err", {29'd0, S_ERR, H_ERR, WREN}, 32'b100);
      tick();
      chk("s_ill_pulse", 32'(S_ERR), 0);

      // Supervisor SERVICE write -> 3 cycles of hold-off; a tie waits and then host wins.
      S_VALID = 1'b1; S_ABUS = 3'd2; S_DBUS = 16'h0008;
      settle();
      chk("svc_ready", 32'(S_READY), 1);
      exp_q.push_back({3'd2, 16'h0008});
      tick();
      chk("svc_wren_busy", {30'd0, WREN, BUSY}, 32'b11);
      H_VALID = 1'b1; H_ABUS = 3'd6; H_DBUS = 16'h0077;
      S_ABUS = 3'd3; S_DBUS = 16'h0099;
      settle();
      chk("hold1_ready", {30'd0, H_READY, S_READY}, 0);
      tick();
      chk("hold2", {29'd0, BUSY, H_READY, S_READY}, 32'b100);
      chk("hold2_wren", 32'(WREN), 0);
      tick();
      chk("hold3", {29'd0, BUSY, H_READY, S_READY}, 32'b100);
      tick();
      chk("post_hold", {29'd0, BUSY, H_READY, S_READY}, 32'b010);
      exp_q.push_back({3'd6, 16'h0077});
      tick();
      chk("post_hold_wren", 32'(WREN), 1);
      H_VALID = 1'b0;
      settle();
      chk("post_hold_s", 32'(S_READY), 1);
      exp_q.push_back({3'd3, 16'h0099});
      tick();
      S_VALID = 1'b0;
      tick();

      // Reset in the first hold-off cycle cancels everything.
      S_VALID = 1'b1; S_ABUS = 3'd2; S_DBUS = 16'h000C;
      settle();
      exp_q.push_back({3'd2, 16'h000C});
      tick();
      chk("svc2_busy", {30'd0, WREN, BUSY}, 32'b11);
      RST = 1'b1;
      H_VALID = 1'b1; H_ABUS = 3'd4; H_DBUS = 16'h0044;
      S_ABUS = 3'd3; S_DBUS = 16'h0011;
      settle();
      chk("rst_hold_ready", {30'd0, H_READY, S_READY}, 0);
      tick();
      chk("rst_hold_outs", {24'd0, WREN, BUSY, H_ERR, S_ERR, 1'b0, ABUS}, 0);
      chk("rst_hold_dbus", 32'(DBUS), 0);
      RST = 1'b0;
      settle();
      chk("rst_tie_h", {30'd0, H_READY, S_READY}, 32'b10);
      exp_q.push_back({3'd4, 16'h0044});
      tick();
      H_VALID = 1'b0;
      settle();
      chk("rst_tie_s", {30'd0, H_READY, S_READY}, 32'b01);
      exp_q.push_back({3'd3, 16'h0011});
      tick();
      S_VALID = 1'b0;
      tick();
      chk("final_idle", {30'd0, WREN, BUSY}, 0);
      chk("queue_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
